// File: rtl/calculator_pkg.sv
// Shared constants, opcodes and state type for the 4-bit calculator unit.
package calculator_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } calc_state_e;

  // Single-cycle operations; operands are zero-extended so subtract wraps to two's complement.
  function automatic logic [RESULT_W-1:0] alu_result(
    input logic [1:0]           op,
    input logic [OPERAND_W-1:0] a,
    input logic [OPERAND_W-1:0] b
  );
    logic [RESULT_W-1:0] a_ext;
    logic [RESULT_W-1:0] b_ext;
    logic [RESULT_W-1:0] res;
    a_ext = {{(RESULT_W-OPERAND_W){1'b0}}, a};
    b_ext = {{(RESULT_W-OPERAND_W){1'b0}}, b};
    case (op)
      OP_ADD:  res = a_ext + b_ext;
      OP_SUB:  res = a_ext - b_ext;
      OP_MUL:  res = a_ext * b_ext;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calculator_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, four steps per divide.
module calculator_divider
  import calculator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [OPERAND_W-1:0] dividend,
  input  logic [OPERAND_W-1:0] divisor,
  output logic [OPERAND_W-1:0] quotient,
  output logic                 finished
);

  logic [OPERAND_W-1:0] dq_q;
  logic [OPERAND_W-1:0] rem_q;
  logic [OPERAND_W-1:0] rem_d;
  logic [OPERAND_W-1:0] dvs_q;
  logic [1:0]           cnt_q;
  logic [1:0]           cnt_d;
  logic                 run_q;
  logic                 run_d;
  logic [OPERAND_W:0]   shifted;
  logic [OPERAND_W:0]   trial;

  // Borrow out of the trial subtraction (trial MSB) means restore: keep the shifted remainder.
  always_comb begin
    shifted  = {rem_q, dq_q[OPERAND_W-1]};
    trial    = shifted - {1'b0, dvs_q};
    rem_d    = trial[OPERAND_W] ? shifted[OPERAND_W-1:0] : trial[OPERAND_W-1:0];
    quotient = {dq_q[OPERAND_W-2:0], ~trial[OPERAND_W]};
    finished = run_q && (cnt_q == 2'd3);
  end

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (load) begin
      run_d = 1'b1;
      cnt_d = 2'd0;
    end else if (run_q) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      dq_q  <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run_q) begin
      dq_q  <= quotient;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/calculator_unit.sv
// 4-bit add/sub/mul/div unit: single-cycle ALU ops, iterative divide, divide-by-zero flag.
module calculator_unit
  import calculator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic [1:0]           op,
  output logic [RESULT_W-1:0]  result,
  output logic                 error,
  output logic                 busy,
  output logic                 done
);

  calc_state_e          state_q;
  calc_state_e          state_d;
  logic [RESULT_W-1:0]  result_q;
  logic [RESULT_W-1:0]  result_d;
  logic                 error_q;
  logic                 error_d;
  logic                 done_q;
  logic                 done_d;
  logic                 div_load;
  logic [OPERAND_W-1:0] div_quot;
  logic                 div_finished;

  calculator_divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (a),
    .divisor  (b),
    .quotient (div_quot),
    .finished (div_finished)
  );

  // Divide by zero completes immediately like an ALU op, flagged instead of iterated.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    error_d  = error_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((op == OP_DIV) && (b != '0)) begin
            div_load = 1'b1;
            state_d  = DIV;
          end else begin
            result_d = alu_result(op, a, b);
            error_d  = (op == OP_DIV);
            done_d   = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_finished) begin
          result_d = {{(RESULT_W-OPERAND_W){1'b0}}, div_quot};
          error_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign error  = error_q;
  assign done   = done_q;
  assign busy   = (state_q == DIV);

endmodule

// File: tb/tb_calculator_unit.sv
// Directed and randomized checks of calculator_unit against an arithmetic reference model.
module tb_calculator_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic [7:0] result;
  logic       error;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  calculator_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .error  (error),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_result(input int ra, input int rb, input int rop);
    case (rop)
      0:       return (ra + rb) % 256;
      1:       return (ra - rb + 256) % 256;
      2:       return ra * rb;
      default: return (rb == 0) ? 0 : ra / rb;
    endcase
  endfunction

  function automatic int ref_error(input int rb, input int rop);
    return (rop == 3 && rb == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [1:0] top);
    int lat;
    int exp_lat;
    exp_lat = (top == 2'b11 && tb_v != 4'd0) ? 5 : 1;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    op    = top;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 12) begin
      check("busy_while_div", {31'd0, busy}, 32'd1);
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", lat, exp_lat);
    check("result", {24'd0, result}, ref_result(ta, tb_v, top));
    check("error", {31'd0, error}, ref_error(tb_v, top));
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    run_op(4'd5, 4'd3, 2'b00);
    run_op(4'd9, 4'd4, 2'b01);
    run_op(4'd3, 4'd5, 2'b01);
    run_op(4'd7, 4'd2, 2'b10);
    run_op(4'd15, 4'd15, 2'b10);
    run_op(4'd8, 4'd2, 2'b11);
    run_op(4'd7, 4'd2, 2'b11);
    run_op(4'd8, 4'd0, 2'b11);
    run_op(4'd1, 4'd2, 2'b00);
    run_op(4'd15, 4'd1, 2'b11);
    run_op(4'd0, 4'd15, 2'b01);

    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);

    // start during a divide must not disturb it
    start = 1'b1; a = 4'd13; b = 4'd3; op = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd1; op = 2'b00;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    check("ign_no_done", {31'd0, done}, 32'd0);
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_latency", lat, 5);
    check("ign_result", {24'd0, result}, 32'd4);
    @(negedge clk);

    // reset in the middle of a divide aborts it
    start = 1'b1; a = 4'd14; b = 4'd3; op = 2'b11;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op(4'd6, 4'd3, 2'b11);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic [1:0] rop;
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_op(ra, rb, rop);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator_unit.md
# calculator_unit

Synchronous 4-bit integer arithmetic unit producing an 8-bit result for add, subtract, multiply and divide, with a divide-by-zero error flag. It is a leaf datapath block driven by a control sequencer through a single-cycle start pulse. Add, subtract and multiply complete in one cycle. Divide runs as a 4-step iterative restoring divider.

## Interface
Parameters: none; widths fixed by shared package constants.
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  reset, synchronous and active-high
- start  input  1  request pulse; a, b, op sampled when start=1 and busy=0
- a  input  4  unsigned operand A (dividend for divide)
- b  input  4  unsigned operand B (divisor for divide)
- op  input  2  operation: 00 add, 01 subtract, 10 multiply, 11 divide
- result  output  8  registered result, held until the next done
- error  output  1  registered; 1 = divide by zero on the last completed operation
- busy  output  1  1 while a divide is iterating; start ignored
- done  output  1  one-cycle pulse when result/error update

## Operation
- Add: result = {4'b0,a} + {4'b0,b}, range 0..30, no overflow possible. Example: 5+3 = 8.
- Subtract: result = 8-bit two's-complement of a-b. Example: 9-4 = 5; 3-5 = 8'hFE.
- Multiply: result = a*b, unsigned, range 0..225. Example: 7*2 = 14.
- Divide, b≠0: result = {4'b0, floor(a/b)}; remainder discarded. Example: 8/2 = 4.
- Divide, b=0: result = 8'h00, error = 1. No iteration.
- error = 0 for every other completed operation.
- States: IDLE and DIV.
- IDLE with start=1 and op≠11, or op=11 with b=0: result and error load on that edge, done pulses, stay in IDLE.
- IDLE with start=1, op=11, b≠0: latch operands, clear iteration counter, go to DIV, busy=1.
- DIV: one restoring step per cycle, MSB first. After the 4th step, load the quotient, pulse done, clear busy, return to IDLE.
- start while busy=1 is ignored; operands are not re-sampled.
- result and error keep their last value between operations.

## Timing
- Reset: result=0, error=0, busy=0, done=0, state IDLE.
- Reset during DIV aborts the divide: no done, outputs go to reset values.
- start sampled at edge k:
  - Add, subtract, multiply, or divide by zero: result/error valid and done=1 in the cycle after edge k.
  - Divide, b≠0: busy=1 after edges k..k+3; the quotient loads and done=1 after edge k+4 (latency 4 cycles). busy=0 in that same cycle.
- A new start is accepted in the cycle where done=1, since busy=0 there.
- done is never high two cycles in a row unless starts are back-to-back single-cycle operations.

## Structure
- Package calculator_pkg holds:
  - OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - OPERAND_W=4, RESULT_W=8
  - a state enum {IDLE, DIV}
- Sub-module calculator_divider: 4-bit restoring divider. It holds the dividend/quotient shift register, the partial remainder and a 2-bit step counter.
  - Inputs: load, dividend, divisor.
  - Outputs: quotient, finished.
- Top level holds the FSM, the single-cycle add/sub/mul datapath and the output registers.

## Test plan
- Reset held 2 cycles, then released: all outputs 0. Then start, a=5, b=3, op=00 -> next cycle done=1, result=8, error=0.
- a=9, b=4, op=01 -> result=5. Then a=3, b=5, op=01 -> result=8'hFE.
- a=7, b=2, op=10 -> result=14. Then a=15, b=15, op=10 -> result=225.
- a=8, b=2, op=11 -> busy high 4 cycles, then done=1, result=4, error=0. Also a=7, b=2 -> result=3.
- a=8, b=0, op=11 -> next cycle done=1, error=1, result=0, busy never set. The following add clears error to 0.
- Start a divide, then:
  - Pulse start with op=00 while busy -> ignored, divide result unaffected.
  - Assert rst mid-divide -> no done, outputs return to 0.
